h264_transform_sched: RTL and testbench

- Scheduler in front of the 4x4 core forward transform. It shares the single transform engine between two residual sources: source 0 is luma and source 1 is chroma.
- Each source hands over a whole 4x4 residual block in one handshake. The block buffers it, arbitrates round-robin and streams it into the core as 4 consecutive row beats.
- It tags each block in flight and relabels the core's 16-beat reverse-zigzag output with source, block index, coefficient index and last flag. The output feeds quantisation.

---
 rtl/h264_transform_sched_if.sv | 43 ++++
 rtl/h264_transform_sched.sv | 173 +++++++++++++++++
 tb/tb_h264_transform_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/h264_transform_sched_if.sv
// Signal bundle between the two residual sources, the forward transform core and quantisation.
// The scheduler takes the slave side; whoever drives the sources and the core takes the master side.
interface h264_transform_sched_if #(
  parameter int BLKW = 8
);
  logic            SOF;
  logic            REQ0_VALID;
  logic [143:0]    REQ0_DATA;
  logic            REQ0_READY;
  logic            REQ1_VALID;
  logic [143:0]    REQ1_DATA;
  logic            REQ1_READY;
  logic            TF_READY;
  logic            TF_ENABLE;
  logic [35:0]     TF_XXIN;
  logic            TF_VALID;
  logic [13:0]     TF_YNOUT;
  logic            OUT_VALID;
  logic [13:0]     OUT_COEF;
  logic            OUT_SRC;
  logic [BLKW-1:0] OUT_BLK;
  logic [3:0]      OUT_IDX;
  logic            OUT_LAST;
  logic            ERR;

  modport slave (
    input  SOF,
    input  REQ0_VALID, REQ0_DATA, output REQ0_READY,
    input  REQ1_VALID, REQ1_DATA, output REQ1_READY,
    input  TF_READY,   output TF_ENABLE, TF_XXIN,
    input  TF_VALID,   TF_YNOUT,
    output OUT_VALID,  OUT_COEF, OUT_SRC, OUT_BLK, OUT_IDX, OUT_LAST, ERR
  );

  modport master (
    output SOF,
    output REQ0_VALID, REQ0_DATA, input REQ0_READY,
    output REQ1_VALID, REQ1_DATA, input REQ1_READY,
    output TF_READY,   input TF_ENABLE, TF_XXIN,
    output TF_VALID,   TF_YNOUT,
    input  OUT_VALID,  OUT_COEF, OUT_SRC, OUT_BLK, OUT_IDX, OUT_LAST, ERR
  );
endinterface

// File: rtl/h264_transform_sched.sv
// Round-robin scheduler sharing one 4x4 forward transform core between luma and chroma:
// one block per accept, 4 row beats one cycle later, 16 output beats relabelled one cycle after the core.
module h264_transform_sched #(
  parameter int BLKW      = 8,
  parameter int TAG_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  h264_transform_sched_if.slave bus
);
  localparam int PW   = $clog2(TAG_DEPTH);
  localparam int TAGW = 1 + BLKW;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e          state_q;
  logic [1:0]      row_q;
  logic [143:0]    blk_dat_q;
  logic            tf_en_q;
  logic [35:0]     tf_xxin_q;

  logic            rr_q, rr_d;
  logic [BLKW-1:0] blkc0_q, blkc0_d;
  logic [BLKW-1:0] blkc1_q, blkc1_d;
  logic [TAGW-1:0] tag_mem_q [TAG_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [PW:0]     occ_q, occ_d;
  logic [3:0]      ocnt_q;

  logic            out_vld_q;
  logic [13:0]     out_coef_q;
  logic            out_src_q;
  logic [BLKW-1:0] out_blk_q;
  logic [3:0]      out_idx_q;
  logic            out_last_q;
  logic            err_q;

  logic            grant_ok, win, acc, pop, fifo_empty;
  logic [BLKW-1:0] acc_blk;
  logic [143:0]    acc_dat;
  logic [TAGW-1:0] head;
  logic [35:0]     blk_row [4];

  always_comb begin
    fifo_empty = (occ_q == '0);
    head       = tag_mem_q[rptr_q];
    // READY is held low while reset is asserted so every output reads 0 then.
    grant_ok   = RESET_N && (state_q == IDLE) && bus.TF_READY &&
                 (occ_q < (PW+1)'(TAG_DEPTH));
    win        = (bus.REQ0_VALID && bus.REQ1_VALID) ? rr_q : bus.REQ1_VALID;
    acc        = grant_ok && (bus.REQ0_VALID || bus.REQ1_VALID);
    acc_dat    = win ? bus.REQ1_DATA : bus.REQ0_DATA;
    acc_blk    = bus.SOF ? '0 : (win ? blkc1_q : blkc0_q);
    pop        = bus.TF_VALID && !fifo_empty && (ocnt_q == 4'd15);
    for (int i = 0; i < 4; i++) begin
      blk_row[i] = blk_dat_q[36*i +: 36];
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (acc && !pop) begin
      occ_d = occ_q + (PW+1)'(1);
    end else if (!acc && pop) begin
      occ_d = occ_q - (PW+1)'(1);
    end
    blkc0_d = bus.SOF ? '0 : blkc0_q;
    blkc1_d = bus.SOF ? '0 : blkc1_q;
    rr_d    = bus.SOF ? 1'b0 : rr_q;
    if (acc) begin
      rr_d = !win;
      if (win) begin
        blkc1_d = acc_blk + BLKW'(1);
      end else begin
        blkc0_d = acc_blk + BLKW'(1);
      end
    end
  end

  assign bus.REQ0_READY = grant_ok && bus.REQ0_VALID && !win;
  assign bus.REQ1_READY = grant_ok && bus.REQ1_VALID && win;
  assign bus.TF_ENABLE  = tf_en_q;
  assign bus.TF_XXIN    = tf_xxin_q;
  assign bus.OUT_VALID  = out_vld_q;
  assign bus.OUT_COEF   = out_coef_q;
  assign bus.OUT_SRC    = out_src_q;
  assign bus.OUT_BLK    = out_blk_q;
  assign bus.OUT_IDX    = out_idx_q;
  assign bus.OUT_LAST   = out_last_q;
  assign bus.ERR        = err_q;

  // Issue FSM: row 0 is loaded straight from the request so the first beat follows the accept edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      row_q     <= 2'd0;
      blk_dat_q <= '0;
      tf_en_q   <= 1'b0;
      tf_xxin_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            state_q   <= ISSUE;
            row_q     <= 2'd0;
            blk_dat_q <= acc_dat;
            tf_en_q   <= 1'b1;
            tf_xxin_q <= acc_dat[35:0];
          end
        end
        ISSUE: begin
          if (row_q == 2'd3) begin
            state_q   <= IDLE;
            row_q     <= 2'd0;
            tf_en_q   <= 1'b0;
            tf_xxin_q <= '0;
          end else begin
            row_q     <= row_q + 2'd1;
            tf_xxin_q <= blk_row[row_q + 2'd1];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rr_q       <= 1'b0;
      blkc0_q    <= '0;
      blkc1_q    <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      ocnt_q     <= 4'd0;
      out_vld_q  <= 1'b0;
      out_coef_q <= '0;
      out_src_q  <= 1'b0;
      out_blk_q  <= '0;
      out_idx_q  <= 4'd0;
      out_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      blkc0_q <= blkc0_d;
      blkc1_q <= blkc1_d;
      occ_q   <= occ_d;
      if (acc) begin
        tag_mem_q[wptr_q] <= {win, acc_blk};
        wptr_q            <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      out_vld_q <= bus.TF_VALID;
      if (bus.TF_VALID) begin
        // A beat with no tag outstanding is still forwarded, labelled luma block 0.
        out_coef_q <= bus.TF_YNOUT;
        out_src_q  <= fifo_empty ? 1'b0 : head[TAGW-1];
        out_blk_q  <= fifo_empty ? '0 : head[BLKW-1:0];
        out_idx_q  <= ocnt_q;
        out_last_q <= (ocnt_q == 4'd15);
        ocnt_q     <= ocnt_q + 4'd1;
        if (fifo_empty) begin
          err_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_h264_transform_sched.sv
// Bench for h264_transform_sched: random and directed traffic, a behavioural transform core,
// and a scoreboard of expected tagged coefficients checked by an independent monitor.
module tb_h264_transform_sched;
  localparam int BLKW      = 2;
  localparam int TAG_DEPTH = 2;
  localparam int ZZ [16]   = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  typedef struct {
    bit           src;
    int           blk;
    logic [143:0] dat;
  } tag_t;

  typedef struct {
    int coef;
    int src;
    int blk;
    int idx;
    int last;
  } beat_t;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  h264_transform_sched_if #(.BLKW(BLKW)) bus ();

  h264_transform_sched #(.BLKW(BLKW), .TAG_DEPTH(TAG_DEPTH)) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  tag_t         m_tags[$];
  logic [35:0]  m_rows[$];
  beat_t        sb[$];
  int           m_busy;
  bit           m_rr;
  int           m_blkc[2];
  int           m_ocnt;
  bit           m_err;

  logic [35:0]  core_rows[$];
  int           core_out[$];
  bit           core_stall;

  logic [143:0] src_q0[$];
  logic [143:0] src_q1[$];
  bit           drv_tfr, drv_sof, drv_inject;

  function automatic int cmat(input int i, input int k);
    case (i)
      0:       return 1;
      1:       return (k == 0) ? 2 : (k == 1) ? 1 : (k == 2) ? -1 : -2;
      2:       return (k == 0 || k == 3) ? 1 : -1;
      default: return (k == 0) ? 1 : (k == 1) ? -2 : (k == 2) ? 2 : -1;
    endcase
  endfunction

  function automatic int px(input logic [143:0] d, input int r, input int c);
    logic signed [8:0] v;
    v = d[36*r + 9*c +: 9];
    return int'(v);
  endfunction

  // Y = C * X * C^T, picked at raster position pos.
  function automatic int coef_of(input logic [143:0] d, input int pos);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < 4; l++) begin
        s += cmat(pos / 4, k) * px(d, k, l) * cmat(pos % 4, l);
      end
    end
    return s;
  endfunction

  function automatic logic [143:0] mk_blk(input bit ramp);
    logic [143:0] d;
    logic [8:0]   v;
    d = '0;
    for (int i = 0; i < 16; i++) begin
      if (ramp) v = 9'(i + 1);
      else      v = 9'($urandom_range(0, 63)) - 9'd32;
      d[9*i +: 9] = v;
    end
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tags.delete(); m_rows.delete(); sb.delete();
    core_rows.delete(); core_out.delete();
    src_q0.delete(); src_q1.delete();
    m_busy = 0; m_rr = 1'b0; m_blkc[0] = 0; m_blkc[1] = 0; m_ocnt = 0; m_err = 1'b0;
  endtask

  // One clock cycle: check registered outputs, act as the core, drive inputs, predict the next edge.
  task automatic step();
    bit           v0, v1, grant_ok, win, acc, tv;
    logic [13:0]  yn;
    logic [35:0]  er;
    logic [143:0] cb;
    tag_t         t;
    beat_t        b;
    @(negedge CLK);
    chk("tf_enable", bus.TF_ENABLE, m_busy > 0);
    if (bus.TF_ENABLE) begin
      if (m_rows.size() == 0) begin
        chk("tf_row_unexpected", 1, 0);
      end else begin
        er = m_rows.pop_front();
        chk("tf_xxin", bus.TF_XXIN, er);
      end
      core_rows.push_back(bus.TF_XXIN);
      if (core_rows.size() == 4) begin
        for (int r = 0; r < 4; r++) cb[36*r +: 36] = core_rows[r];
        for (int k = 0; k < 16; k++) core_out.push_back(coef_of(cb, ZZ[15-k]));
        core_rows.delete();
      end
    end
    chk("err", bus.ERR, m_err);

    v0 = src_q0.size() > 0;
    v1 = src_q1.size() > 0;
    bus.REQ0_VALID = v0;
    bus.REQ0_DATA  = v0 ? src_q0[0] : '0;
    bus.REQ1_VALID = v1;
    bus.REQ1_DATA  = v1 ? src_q1[0] : '0;
    bus.TF_READY   = drv_tfr;
    bus.SOF        = drv_sof;
    tv = 1'b0;
    yn = '0;
    if (drv_inject) begin
      tv = 1'b1;
      yn = 14'h0abc;
    end else if (!core_stall && core_out.size() > 0) begin
      tv = 1'b1;
      yn = 14'(core_out.pop_front());
    end
    bus.TF_VALID = tv;
    bus.TF_YNOUT = yn;
    #1;

    grant_ok = (m_busy == 0) && drv_tfr && (m_tags.size() < TAG_DEPTH);
    win      = (v0 && v1) ? m_rr : v1;
    if (v0) chk("req0_ready", bus.REQ0_READY, grant_ok && !win);
    if (v1) chk("req1_ready", bus.REQ1_READY, grant_ok && win);
    acc = grant_ok && (v0 || v1);

    if (tv) begin
      b.idx  = m_ocnt;
      b.last = (m_ocnt == 15) ? 1 : 0;
      if (m_tags.size() == 0) begin
        m_err  = 1'b1;
        b.src  = 0;
        b.blk  = 0;
        b.coef = int'($signed(yn));
      end else begin
        b.src  = int'(m_tags[0].src);
        b.blk  = m_tags[0].blk;
        b.coef = coef_of(m_tags[0].dat, ZZ[15-m_ocnt]);
        if (m_ocnt == 15) void'(m_tags.pop_front());
      end
      sb.push_back(b);
      m_ocnt = (m_ocnt + 1) % 16;
    end

    if (drv_sof) begin
      m_blkc[0] = 0;
      m_blkc[1] = 0;
      m_rr      = 1'b0;
    end
    if (acc) begin
      t.src = win;
      t.blk = m_blkc[win];
      if (win) t.dat = src_q1.pop_front();
      else     t.dat = src_q0.pop_front();
      m_blkc[win] = (m_blkc[win] + 1) % (1 << BLKW);
      m_rr = !win;
      m_tags.push_back(t);
      for (int r = 0; r < 4; r++) m_rows.push_back(t.dat[36*r +: 36]);
      m_busy = 4;
    end else if (m_busy > 0) begin
      m_busy--;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    drv_tfr = 1'b1; core_stall = 1'b0; drv_sof = 1'b0; drv_inject = 1'b0;
    while ((src_q0.size() + src_q1.size() + m_tags.size() + core_out.size() +
            core_rows.size() + sb.size()) != 0 && n < 3000) begin
      step();
      n++;
    end
    chk("drain_in_budget", n < 3000, 1);
  endtask

  // Output monitor: every OUT_VALID beat must match the oldest expected beat.
  initial begin
    beat_t b;
    forever begin
      @(negedge CLK);
      if (RESET_N && bus.OUT_VALID) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL out_unexpected: beat coef %0d idx %0d with nothing expected", $signed(bus.OUT_COEF), bus.OUT_IDX);
        end else begin
          b = sb.pop_front();
          if (int'($signed(bus.OUT_COEF)) != b.coef || int'(bus.OUT_SRC) != b.src ||
              int'(bus.OUT_BLK) != b.blk || int'(bus.OUT_IDX) != b.idx || int'(bus.OUT_LAST) != b.last) begin
            n_bad++;
            $display("FAIL out_beat: got coef %0d src %0d blk %0d idx %0d last %0d, expected coef %0d src %0d blk %0d idx %0d last %0d",
                     $signed(bus.OUT_COEF), bus.OUT_SRC, bus.OUT_BLK, bus.OUT_IDX, bus.OUT_LAST,
                     b.coef, b.src, b.blk, b.idx, b.last);
          end
        end
      end
    end
  end

  initial begin
    int  n;
    bit  sof_done;
    bus.SOF = 1'b0; bus.TF_VALID = 1'b0; bus.TF_YNOUT = '0;
    drv_tfr = 1'b0; drv_sof = 1'b0; drv_inject = 1'b0; core_stall = 1'b0;
    model_reset();

    // Reset state, with requests and core READY already asserted.
    bus.REQ0_VALID = 1'b1; bus.REQ0_DATA = mk_blk(1'b0);
    bus.REQ1_VALID = 1'b1; bus.REQ1_DATA = mk_blk(1'b0);
    bus.TF_READY   = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req0_ready", bus.REQ0_READY, 0);
    chk("rst_req1_ready", bus.REQ1_READY, 0);
    chk("rst_tf_enable",  bus.TF_ENABLE, 0);
    chk("rst_tf_xxin",    bus.TF_XXIN, 0);
    chk("rst_out_valid",  bus.OUT_VALID, 0);
    chk("rst_out_coef",   bus.OUT_COEF, 0);
    chk("rst_out_src",    bus.OUT_SRC, 0);
    chk("rst_out_blk",    bus.OUT_BLK, 0);
    chk("rst_out_idx",    bus.OUT_IDX, 0);
    chk("rst_out_last",   bus.OUT_LAST, 0);
    chk("rst_err",        bus.ERR, 0);
    bus.REQ0_VALID = 1'b0; bus.REQ1_VALID = 1'b0; bus.TF_READY = 1'b0;
    RESET_N = 1'b1;

    // Single luma ramp block: DC at the final beat is 1+..+16.
    src_q0.push_back(mk_blk(1'b1));
    drain();

    // Both sources saturated: grants alternate and per-source indices advance.
    for (int i = 0; i < 4; i++) begin
      src_q0.push_back(mk_blk(1'b0));
      src_q1.push_back(mk_blk(1'b0));
    end
    drain();

    // Core not ready: the request waits, then is taken once READY rises.
    src_q0.push_back(mk_blk(1'b0));
    drv_tfr = 1'b0;
    repeat (8) step();
    drain();

    // Tag FIFO full while the core output is stalled.
    core_stall = 1'b1; drv_tfr = 1'b1;
    for (int i = 0; i < 3; i++) src_q0.push_back(mk_blk(1'b0));
    repeat (20) step();
    drain();

    // A chroma accept landing on the cycle the head tag pops.
    core_stall = 1'b1; drv_tfr = 1'b1;
    src_q0.push_back(mk_blk(1'b0));
    repeat (8) step();
    src_q1.push_back(mk_blk(1'b0));
    core_stall = 1'b0;
    for (int i = 0; i < 40 && src_q1.size() > 0; i++) begin
      drv_tfr = (core_out.size() == 1 && m_ocnt == 15);
      step();
    end
    drain();

    // Block index wrap, and SOF during the fourth block's issue restarts numbering.
    drv_sof = 1'b1; step(); drv_sof = 1'b0;
    for (int i = 0; i < 5; i++) src_q0.push_back(mk_blk(1'b0));
    n = 0; sof_done = 1'b0;
    while (src_q0.size() > 0 && n < 500) begin
      if (!sof_done && src_q0.size() == 1 && m_busy == 3) begin
        drv_sof = 1'b1;
        sof_done = 1'b1;
      end
      step();
      drv_sof = 1'b0;
      n++;
    end
    chk("sof_pulse_placed", sof_done, 1);
    drain();

    // Random traffic: sparse requests, flickering core READY, output stalls, stray SOFs.
    for (int i = 0; i < 800; i++) begin
      if (src_q0.size() == 0 && $urandom_range(0, 3) == 0) src_q0.push_back(mk_blk(1'b0));
      if (src_q1.size() == 0 && $urandom_range(0, 3) == 0) src_q1.push_back(mk_blk(1'b0));
      drv_tfr    = ($urandom_range(0, 7) != 0);
      core_stall = ($urandom_range(0, 5) == 0);
      drv_sof    = ($urandom_range(0, 39) == 0);
      step();
    end
    drain();

    // Core beat with nothing in flight: flagged and sticky.
    drv_inject = 1'b1; step(); drv_inject = 1'b0;
    repeat (5) step();

    // Reset pulled in the middle of an issue.
    src_q0.push_back(mk_blk(1'b0));
    n = 0;
    while (m_busy != 2 && n < 50) begin
      step();
      n++;
    end
    chk("tf_enable_before_reset", bus.TF_ENABLE, m_busy > 0);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_rst_tf_enable", bus.TF_ENABLE, 0);
    chk("async_rst_err",       bus.ERR, 0);
    chk("async_rst_out_valid", bus.OUT_VALID, 0);
    model_reset();
    drv_tfr = 1'b0; core_stall = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
